// File: rtl/rsa256_stream_ctrl_if.sv
// Byte-stream and core-side signal bundle for rsa256_stream_ctrl.
// Signal names are seen from the controller: i_* enter it, o_* leave it.
interface rsa256_stream_ctrl_if #(
  parameter int unsigned WORD_W = 256
);
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_rx_ready;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_core_start;
  logic [WORD_W-1:0] o_core_a;
  logic [WORD_W-1:0] o_core_e;
  logic [WORD_W-1:0] o_core_n;
  logic [WORD_W-1:0] i_core_result;
  logic              i_core_finished;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_core_result, i_core_finished,
    output o_rx_ready, o_tx_data, o_tx_valid, o_core_start,
           o_core_a, o_core_e, o_core_n
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready, i_core_result, i_core_finished,
    input  o_rx_ready, o_tx_data, o_tx_valid, o_core_start,
           o_core_a, o_core_e, o_core_n
  );
endinterface

// File: rtl/rsa256_stream_ctrl.sv
// Byte-stream front end for an RSA-256 core: assembles n, e and ciphertext
// words, launches the core per block and serializes the truncated result.
module rsa256_stream_ctrl #(
  parameter int unsigned IN_BYTES  = 32,
  parameter int unsigned OUT_BYTES = 31
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rsa256_stream_ctrl_if.slave  bus
);

  localparam int unsigned WORD_W = 8 * IN_BYTES;
  localparam int unsigned OUT_W  = 8 * OUT_BYTES;
  localparam int unsigned CNT_W  = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(IN_BYTES - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(OUT_BYTES - 1);

  typedef enum logic [2:0] {
    S_GET_N,
    S_GET_E,
    S_GET_A,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] r_n;
  logic [WORD_W-1:0] r_e;
  logic [WORD_W-1:0] r_a;
  logic [OUT_W-1:0]  r_tx;
  logic              r_rx_ready;
  logic              r_tx_valid;
  logic              r_core_start;

  logic              w_rx_fire;
  logic              w_tx_fire;
  logic              w_rx_last;
  logic              w_tx_last;
  logic              w_finish;
  logic [WORD_W-1:0] w_word_nxt;

  // Ready/valid flops are only ever high in their owning states, so a fire
  // also implies the matching state.
  assign w_rx_fire  = bus.i_rx_valid && r_rx_ready;
  assign w_tx_fire  = r_tx_valid && bus.i_tx_ready;
  assign w_rx_last  = (r_cnt == RX_LAST);
  assign w_tx_last  = (r_cnt == TX_LAST);
  assign w_finish   = (r_state == S_WAIT) && bus.i_core_finished;
  assign w_word_nxt = {r_word[WORD_W-9:0], bus.i_rx_data};

  assign bus.o_rx_ready   = r_rx_ready;
  assign bus.o_tx_valid   = r_tx_valid;
  assign bus.o_tx_data    = r_tx[OUT_W-1 -: 8];
  assign bus.o_core_start = r_core_start;
  assign bus.o_core_a     = r_a;
  assign bus.o_core_e     = r_e;
  assign bus.o_core_n     = r_n;

  // Result bits above the transmitted width are dropped.
  generate
    if (OUT_W < WORD_W) begin : g_trunc
      logic w_unused_result;
      assign w_unused_result = ^bus.i_core_result[WORD_W-1:OUT_W];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_GET_N;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_GET_N: if (w_rx_fire && w_rx_last) w_state_nxt = S_GET_E;
      S_GET_E: if (w_rx_fire && w_rx_last) w_state_nxt = S_GET_A;
      S_GET_A: if (w_rx_fire && w_rx_last) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.i_core_finished) w_state_nxt = S_SEND;
      S_SEND:  if (w_tx_fire && w_tx_last) w_state_nxt = S_GET_A;
      default: w_state_nxt = S_GET_N;
    endcase
  end

  // Handshake flags are decoded from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_word       <= '0;
      r_n          <= '0;
      r_e          <= '0;
      r_a          <= '0;
      r_tx         <= '0;
      r_rx_ready   <= 1'b1;
      r_tx_valid   <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_rx_ready   <= (w_state_nxt == S_GET_N) || (w_state_nxt == S_GET_E) ||
                      (w_state_nxt == S_GET_A);
      r_tx_valid   <= (w_state_nxt == S_SEND);
      r_core_start <= (w_state_nxt == S_START);

      if (w_rx_fire) begin
        r_word <= w_word_nxt;
        r_cnt  <= w_rx_last ? '0 : r_cnt + CNT_W'(1);
        if (w_rx_last) begin
          case (r_state)
            S_GET_N: r_n <= w_word_nxt;
            S_GET_E: r_e <= w_word_nxt;
            S_GET_A: r_a <= w_word_nxt;
            default: ;
          endcase
        end
      end

      if (w_finish) begin
        r_tx  <= bus.i_core_result[OUT_W-1:0];
        r_cnt <= '0;
      end

      if (w_tx_fire) begin
        r_tx  <= {r_tx[OUT_W-9:0], 8'h00};
        r_cnt <= w_tx_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
